// File: rtl/i_decode_param_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALU codes, stall lengths.
// WB_BYPASS_EN selects same-cycle WB forwarding on the register-file read
// ports; the branch stall lengths shrink by one cycle when it is defined.
package i_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_SUB  = 6'h22;

`ifdef WB_BYPASS_EN
  localparam bit         WB_BYPASS    = 1'b1;
  localparam logic [2:0] STALL_ALU_BR = 3'd2;
  localparam logic [2:0] STALL_LD_BR  = 3'd3;
`else
  localparam bit         WB_BYPASS    = 1'b0;
  localparam logic [2:0] STALL_ALU_BR = 3'd3;
  localparam logic [2:0] STALL_LD_BR  = 3'd4;
`endif

  // EX-stage forwarding covers everything past the first cycle of a load-use
  localparam logic [2:0] STALL_LD     = 3'd1;

  typedef enum logic [2:0] {
    INSTR_R,
    INSTR_ADDI,
    INSTR_LW,
    INSTR_SW,
    INSTR_BEQ,
    INSTR_BNE,
    INSTR_J,
    INSTR_ILL
  } instr_kind_e;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [5:0] alu_op;
  } idex_ctrl_t;

  function automatic instr_kind_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE: return INSTR_R;
      OP_ADDI:  return INSTR_ADDI;
      OP_LW:    return INSTR_LW;
      OP_SW:    return INSTR_SW;
      OP_BEQ:   return INSTR_BEQ;
      OP_BNE:   return INSTR_BNE;
      OP_J:     return INSTR_J;
      default:  return INSTR_ILL;
    endcase
  endfunction

endpackage

// File: rtl/i_decode_param_if.sv
// IF/ID, WB and EX-hazard inputs plus ID/EX and redirect outputs of the
// decode stage. master = surrounding pipeline, slave = decode stage.
interface i_decode_param_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  // IF/ID
  logic                  if_valid;
  logic [31:0]           instruction_in;
  logic [31:0]           npc_in;
  // WB write port
  logic                  RegWriteFromWB;
  logic [REG_ADDR_W-1:0] writeRegister3;
  logic [DATA_W-1:0]     writeData;
  // instruction currently in EX
  logic                  EXMemRead_wire;
  logic                  EXRegWrite_wire;
  logic [REG_ADDR_W-1:0] EXRegRt_wire;
  logic [REG_ADDR_W-1:0] EXWriteReg_wire;
  // hazard / redirect
  logic                  PCWrite_wire;
  logic                  IFIDWrite_wire;
  logic                  IFFlush_wire;
  logic                  branchTaken;
  logic [31:0]           add_outWire;
  // ID/EX
  logic                  valid_out;
  logic                  branch_out;
  logic                  jump_out;
  logic                  AluSrc_out;
  logic                  MemRead_out;
  logic                  MemWrite_out;
  logic                  RegWrite_out;
  logic                  RegDst_out;
  logic                  MemtoReg_out;
  logic [5:0]            AluOp_out;
  logic [31:0]           npc_out;
  logic [DATA_W-1:0]     readdata1_out;
  logic [DATA_W-1:0]     readdata2_out;
  logic [DATA_W-1:0]     sigext_out;
  logic [REG_ADDR_W-1:0] rs_out;
  logic [REG_ADDR_W-1:0] rt_out;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  illegal_out;

  modport master (
    output if_valid, instruction_in, npc_in,
    output RegWriteFromWB, writeRegister3, writeData,
    output EXMemRead_wire, EXRegWrite_wire, EXRegRt_wire, EXWriteReg_wire,
    input  PCWrite_wire, IFIDWrite_wire, IFFlush_wire, branchTaken, add_outWire,
    input  valid_out, branch_out, jump_out, AluSrc_out, MemRead_out, MemWrite_out,
    input  RegWrite_out, RegDst_out, MemtoReg_out, AluOp_out, npc_out,
    input  readdata1_out, readdata2_out, sigext_out, rs_out, rt_out, rd_out,
    input  illegal_out
  );

  modport slave (
    input  if_valid, instruction_in, npc_in,
    input  RegWriteFromWB, writeRegister3, writeData,
    input  EXMemRead_wire, EXRegWrite_wire, EXRegRt_wire, EXWriteReg_wire,
    output PCWrite_wire, IFIDWrite_wire, IFFlush_wire, branchTaken, add_outWire,
    output valid_out, branch_out, jump_out, AluSrc_out, MemRead_out, MemWrite_out,
    output RegWrite_out, RegDst_out, MemtoReg_out, AluOp_out, npc_out,
    output readdata1_out, readdata2_out, sigext_out, rs_out, rt_out, rd_out,
    output illegal_out
  );
endinterface

// File: rtl/i_decode_param_regfile.sv
// Register file: 2 combinational read ports, 1 write port, register 0 hard-wired
// to zero. BYPASS forwards a same-cycle WB write to the read ports.
module regfile_p #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0]     wd_i,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  input  logic [REG_ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0]     rd1_o,
  output logic [DATA_W-1:0]     rd2_o
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];
  logic              wr_en;

  assign wr_en = we_i && (wa_i != '0);

  // Write port; register 0 is never written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Read ports: zero for r0, optional same-cycle forwarding of the WB write
  always_comb begin
    rd1_o = mem_q[ra1_i];
    rd2_o = mem_q[ra2_i];
    if (BYPASS && wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
    if (BYPASS && wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/i_decode_param.sv
// MIPS ID stage: register file, decode into ID/EX, branch/jump resolution and
// the hazard stall counter. Optional feature macro: WB_BYPASS_EN (same-cycle
// WB forwarding on the read ports, shorter branch stalls).
module i_decode_param
  import i_decode_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic         CLK,
  input logic         RST,
  i_decode_param_if.slave bus
);

  logic [31:0]                instr;
  logic [REG_ADDR_W-1:0]      rs, rt, rd;
  instr_kind_e                kind;
  logic                       uses_rs, uses_rt, is_branch;
  logic [DATA_W-1:0]          rd1, rd2;
  logic signed [DATA_W-1:0]   sigext;
  logic signed [31:0]         br_off;

  logic [2:0]                 stall_cnt_q, stall_cnt_d;
  logic [2:0]                 hazard_len;
  logic                       ld_hit, alu_hit, stall, accept, taken;
  logic                       illegal_q;

  idex_ctrl_t                 ctrl_d, ctrl_q;
  logic [31:0]                npc_q;
  logic [DATA_W-1:0]          rd1_q, rd2_q, sigext_q;
  logic [REG_ADDR_W-1:0]      rs_q, rt_q, rd_q;

  assign instr     = bus.instruction_in;
  assign rs        = REG_ADDR_W'(instr[25:21]);
  assign rt        = REG_ADDR_W'(instr[20:16]);
  assign rd        = REG_ADDR_W'(instr[15:11]);
  assign kind      = classify(instr[31:26]);
  assign uses_rs   = (kind != INSTR_J) && (kind != INSTR_ILL);
  assign uses_rt   = kind inside {INSTR_R, INSTR_SW, INSTR_BEQ, INSTR_BNE};
  assign is_branch = (kind == INSTR_BEQ) || (kind == INSTR_BNE);
  assign sigext    = DATA_W'(signed'(instr[15:0]));
  assign br_off    = 32'(signed'(instr[15:0])) <<< 2;

  regfile_p #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W),
    .BYPASS    (WB_BYPASS)
  ) u_rf (
    .clk_i (CLK),
    .rst_i (RST),
    .we_i  (bus.RegWriteFromWB),
    .wa_i  (bus.writeRegister3),
    .wd_i  (bus.writeData),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  // Hazard detection: only a fresh instruction with an idle counter is checked
  always_comb begin
    ld_hit  = bus.EXMemRead_wire && (bus.EXRegRt_wire != '0) &&
              ((uses_rs && (bus.EXRegRt_wire == rs)) ||
               (uses_rt && (bus.EXRegRt_wire == rt)));
    alu_hit = is_branch && bus.EXRegWrite_wire && (bus.EXWriteReg_wire != '0) &&
              ((bus.EXWriteReg_wire == rs) || (bus.EXWriteReg_wire == rt));
    hazard_len = '0;
    if (!RST && bus.if_valid && (stall_cnt_q == '0)) begin
      if (is_branch && ld_hit) hazard_len = STALL_LD_BR;
      else if (alu_hit)        hazard_len = STALL_ALU_BR;
      else if (ld_hit)         hazard_len = STALL_LD;
    end
    // this cycle is the first stall cycle, so the counter holds the remainder
    stall = !RST && ((stall_cnt_q != '0) || (hazard_len != '0));
    if (stall_cnt_q != '0)       stall_cnt_d = stall_cnt_q - 3'd1;
    else if (hazard_len != '0)   stall_cnt_d = hazard_len - 3'd1;
    else                         stall_cnt_d = '0;
  end

  assign accept = !RST && bus.if_valid && !stall;
  assign taken  = accept && ((kind == INSTR_J) ||
                             ((kind == INSTR_BEQ) && (rd1 == rd2)) ||
                             ((kind == INSTR_BNE) && (rd1 != rd2)));

  assign bus.PCWrite_wire   = !stall;
  assign bus.IFIDWrite_wire = !stall;
  assign bus.IFFlush_wire   = taken;
  assign bus.branchTaken    = taken;
  assign bus.add_outWire    = (kind == INSTR_J) ?
                              {bus.npc_in[31:28], instr[25:0], 2'b00} :
                              bus.npc_in + br_off;

  // Control decode; anything not accepted or unsupported stays a bubble
  always_comb begin
    ctrl_d = '0;
    if (accept) begin
      unique case (kind)
        INSTR_R:    begin ctrl_d.valid = 1'b1; ctrl_d.reg_write = 1'b1;
                          ctrl_d.reg_dst = 1'b1; ctrl_d.alu_op = instr[5:0]; end
        INSTR_ADDI: begin ctrl_d.valid = 1'b1; ctrl_d.alu_src = 1'b1;
                          ctrl_d.reg_write = 1'b1; ctrl_d.alu_op = ALU_ADD; end
        INSTR_LW:   begin ctrl_d.valid = 1'b1; ctrl_d.alu_src = 1'b1;
                          ctrl_d.mem_read = 1'b1; ctrl_d.reg_write = 1'b1;
                          ctrl_d.mem_to_reg = 1'b1; ctrl_d.alu_op = ALU_ADD; end
        INSTR_SW:   begin ctrl_d.valid = 1'b1; ctrl_d.alu_src = 1'b1;
                          ctrl_d.mem_write = 1'b1; ctrl_d.alu_op = ALU_ADD; end
        INSTR_BEQ,
        INSTR_BNE:  begin ctrl_d.valid = 1'b1; ctrl_d.branch = 1'b1;
                          ctrl_d.alu_op = ALU_SUB; end
        INSTR_J:    begin ctrl_d.valid = 1'b1; ctrl_d.jump = 1'b1; end
        default:    ctrl_d = '0;
      endcase
    end
  end

  // Stall counter and sticky illegal-opcode flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (accept && (kind == INSTR_ILL)) illegal_q <= 1'b1;
    end
  end

  // ID/EX register; a bubble clears every field
  always_ff @(posedge CLK) begin
    if (RST || !ctrl_d.valid) begin
      ctrl_q   <= '0;
      npc_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      sigext_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      npc_q    <= bus.npc_in;
      rd1_q    <= rd1;
      rd2_q    <= rd2;
      sigext_q <= sigext;
      rs_q     <= rs;
      rt_q     <= rt;
      rd_q     <= rd;
    end
  end

  assign bus.valid_out     = ctrl_q.valid;
  assign bus.branch_out    = ctrl_q.branch;
  assign bus.jump_out      = ctrl_q.jump;
  assign bus.AluSrc_out    = ctrl_q.alu_src;
  assign bus.MemRead_out   = ctrl_q.mem_read;
  assign bus.MemWrite_out  = ctrl_q.mem_write;
  assign bus.RegWrite_out  = ctrl_q.reg_write;
  assign bus.RegDst_out    = ctrl_q.reg_dst;
  assign bus.MemtoReg_out  = ctrl_q.mem_to_reg;
  assign bus.AluOp_out     = ctrl_q.alu_op;
  assign bus.npc_out       = npc_q;
  assign bus.readdata1_out = rd1_q;
  assign bus.readdata2_out = rd2_q;
  assign bus.sigext_out    = sigext_q;
  assign bus.rs_out        = rs_q;
  assign bus.rt_out        = rt_q;
  assign bus.rd_out        = rd_q;
  assign bus.illegal_out   = illegal_q;

endmodule

// File: tb/tb_i_decode_param.sv
// Self-checking bench for i_decode_param (directed scenarios + random decode).
module tb_i_decode_param;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

`ifdef WB_BYPASS_EN
  localparam bit BYP        = 1'b1;
  localparam int EXP_ALU_BR = 2;
  localparam int EXP_LD_BR  = 3;
`else
  localparam bit BYP        = 1'b0;
  localparam int EXP_ALU_BR = 3;
  localparam int EXP_LD_BR  = 4;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  i_decode_param_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  i_decode_param #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // architectural register model
  logic [31:0] mrf [32];

  // ---------------- reference model ----------------
  // Expected ID/EX word: {valid,branch,jump,alusrc,memrd,memwr,regwr,regdst,memtoreg,aluop,npc,rd1,rd2,sigext,rs,rt,rd}
  function automatic logic [157:0] exp_idex(input logic [31:0] ins, input logic [31:0] npc,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [8:0]  c;
    logic [5:0]  alu;
    logic [31:0] se;
    se = {{16{ins[15]}}, ins[15:0]};
    case (ins[31:26])
      6'h00:        begin c = 9'b100000110; alu = ins[5:0]; end
      6'h08:        begin c = 9'b100100100; alu = 6'h20;    end
      6'h23:        begin c = 9'b100110101; alu = 6'h20;    end
      6'h2B:        begin c = 9'b100101000; alu = 6'h20;    end
      6'h04, 6'h05: begin c = 9'b110000000; alu = 6'h22;    end
      6'h02:        begin c = 9'b101000000; alu = 6'h00;    end
      default:      return '0;
    endcase
    return {c, alu, npc, a, b, se, ins[25:21], ins[20:16], ins[15:11]};
  endfunction

  function automatic logic [157:0] act_idex();
    return {bus.valid_out, bus.branch_out, bus.jump_out, bus.AluSrc_out, bus.MemRead_out,
            bus.MemWrite_out, bus.RegWrite_out, bus.RegDst_out, bus.MemtoReg_out, bus.AluOp_out,
            bus.npc_out, bus.readdata1_out, bus.readdata2_out, bus.sigext_out,
            bus.rs_out, bus.rt_out, bus.rd_out};
  endfunction

  // register value seen by ID this cycle given the WB port currently driven
  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (BYP && bus.RegWriteFromWB && bus.writeRegister3 == r) return bus.writeData;
    return mrf[r];
  endfunction

  function automatic logic exp_taken(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    return (ins[31:26] == 6'h02) || (ins[31:26] == 6'h04 && a == b) || (ins[31:26] == 6'h05 && a != b);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] ins, input logic [31:0] npc);
    logic [31:0] se;
    se = {{16{ins[15]}}, ins[15:0]};
    if (ins[31:26] == 6'h02) return {npc[31:28], ins[25:0], 2'b00};
    return npc + se * 4;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < 32; i++) mrf[i] = '0;
    end else if (bus.RegWriteFromWB && bus.writeRegister3 != 0) begin
      mrf[bus.writeRegister3] = bus.writeData;
    end
    #1;
  endtask

  task automatic idle();
    bus.if_valid = 0; bus.instruction_in = '0; bus.npc_in = '0;
    bus.RegWriteFromWB = 0; bus.writeRegister3 = '0; bus.writeData = '0;
    bus.EXMemRead_wire = 0; bus.EXRegWrite_wire = 0;
    bus.EXRegRt_wire = '0; bus.EXWriteReg_wire = '0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    bus.if_valid = 0;
    bus.RegWriteFromWB = 1; bus.writeRegister3 = r; bus.writeData = d;
    tick();
    bus.RegWriteFromWB = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); RST = 1; tick(); tick(); RST = 0; #1;
    n_chk++; if (act_idex() !== '0) begin n_fail++; $display("FAIL reset_idex: got %h want 0", act_idex()); end
    n_chk++; if (bus.illegal_out !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.illegal_out); end
    n_chk++; if (bus.PCWrite_wire !== 1'b1 || bus.IFIDWrite_wire !== 1'b1) begin n_fail++;
      $display("FAIL reset_pcwrite: got %b%b want 11", bus.PCWrite_wire, bus.IFIDWrite_wire); end
  endtask

  task automatic test_decode_add();
    logic [157:0] e;
    idle(); bus.if_valid = 1; bus.instruction_in = 32'h012DB820; bus.npc_in = 32'd1; #1;
    n_chk++; if (bus.PCWrite_wire !== 1'b1 || bus.branchTaken !== 1'b0) begin n_fail++;
      $display("FAIL add_comb: pcw=%b taken=%b want 1,0", bus.PCWrite_wire, bus.branchTaken); end
    e = exp_idex(32'h012DB820, 32'd1, model_read(5'd9), model_read(5'd13));
    tick(); bus.if_valid = 0;
    n_chk++; if (act_idex() !== e) begin n_fail++; $display("FAIL add_idex: got %h want %h", act_idex(), e); end
    n_chk++; if (bus.rs_out !== 5'd9 || bus.rt_out !== 5'h0D || bus.rd_out !== 5'h17) begin n_fail++;
      $display("FAIL add_fields: got %h %h %h want 09 0d 17", bus.rs_out, bus.rt_out, bus.rd_out); end
    n_chk++; if (bus.sigext_out !== 32'hFFFFB820 || bus.AluOp_out !== 6'h20) begin n_fail++;
      $display("FAIL add_sigext: got %h/%h want ffffb820/20", bus.sigext_out, bus.AluOp_out); end
  endtask

  task automatic test_load_use();
    logic [157:0] e;
    idle(); bus.if_valid = 1; bus.instruction_in = 32'h012DB820; bus.npc_in = 32'd1;
    bus.EXMemRead_wire = 1; bus.EXRegRt_wire = 5'd9; #1;
    n_chk++; if (bus.PCWrite_wire !== 1'b0 || bus.IFIDWrite_wire !== 1'b0 || bus.IFFlush_wire !== 1'b0) begin n_fail++;
      $display("FAIL ldu_stall: pcw=%b ifid=%b flush=%b want 0 0 0", bus.PCWrite_wire, bus.IFIDWrite_wire, bus.IFFlush_wire); end
    tick(); bus.EXMemRead_wire = 0; #1;
    n_chk++; if (act_idex() !== '0) begin n_fail++; $display("FAIL ldu_bubble: got %h want 0", act_idex()); end
    n_chk++; if (bus.PCWrite_wire !== 1'b1) begin n_fail++; $display("FAIL ldu_len: pcw=%b want 1", bus.PCWrite_wire); end
    e = exp_idex(32'h012DB820, 32'd1, model_read(5'd9), model_read(5'd13));
    tick(); bus.if_valid = 0;
    n_chk++; if (act_idex() !== e) begin n_fail++; $display("FAIL ldu_issue: got %h want %h", act_idex(), e); end
  endtask

  // beq $1,$2 behind a hazard; counts stall cycles, then checks resolution
  task automatic branch_stall(input string nm, input logic ld, input logic [15:0] off,
                              input logic [31:0] npc, input int exp_len);
    logic [31:0] ins;
    logic [157:0] e;
    int stalls;
    ins = {6'h04, 5'd1, 5'd2, off};
    idle(); bus.if_valid = 1; bus.instruction_in = ins; bus.npc_in = npc;
    bus.EXRegWrite_wire = 1; bus.EXWriteReg_wire = ld ? 5'd2 : 5'd1;
    bus.EXMemRead_wire = ld; bus.EXRegRt_wire = 5'd2;
    #1;
    stalls = 0;
    while (bus.PCWrite_wire === 1'b0 && stalls < 8) begin
      n_chk++; if (bus.branchTaken !== 1'b0) begin n_fail++; $display("FAIL %s_taken_in_stall: got %b want 0", nm, bus.branchTaken); end
      tick(); stalls++;
      bus.EXRegWrite_wire = 0; bus.EXMemRead_wire = 0;
      n_chk++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL %s_bubble: valid=%b want 0", nm, bus.valid_out); end
      #1;
    end
    n_chk++; if (stalls != exp_len) begin n_fail++; $display("FAIL %s_len: got %0d want %0d", nm, stalls, exp_len); end
    n_chk++; if (bus.branchTaken !== 1'b1 || bus.IFFlush_wire !== 1'b1) begin n_fail++;
      $display("FAIL %s_taken: got %b/%b want 1/1", nm, bus.branchTaken, bus.IFFlush_wire); end
    n_chk++; if (bus.add_outWire !== exp_target(ins, npc)) begin n_fail++;
      $display("FAIL %s_target: got %h want %h", nm, bus.add_outWire, exp_target(ins, npc)); end
    e = exp_idex(ins, npc, model_read(5'd1), model_read(5'd2));
    tick(); bus.if_valid = 0;
    n_chk++; if (act_idex() !== e) begin n_fail++; $display("FAIL %s_issue: got %h want %h", nm, act_idex(), e); end
  endtask

  task automatic test_branch_hazards();
    idle(); wb_write(5'd1, 32'd5); wb_write(5'd2, 32'd5);
    branch_stall("br_alu", 1'b0, 16'h0010, 32'h0000_0100, EXP_ALU_BR);
    branch_stall("br_ld",  1'b1, 16'hFFFF, 32'h0000_0000, EXP_LD_BR);
  endtask

  task automatic test_bypass();
    logic [31:0] ins;
    logic [157:0] e;
    ins = {6'h05, 5'd4, 5'd0, 16'h0004};
    idle(); bus.if_valid = 1; bus.instruction_in = ins; bus.npc_in = 32'h200;
    bus.RegWriteFromWB = 1; bus.writeRegister3 = 5'd4; bus.writeData = 32'hA5; #1;
    n_chk++; if (bus.branchTaken !== BYP) begin n_fail++; $display("FAIL byp_taken: got %b want %b", bus.branchTaken, BYP); end
    e = exp_idex(ins, 32'h200, model_read(5'd4), 32'd0);
    tick(); bus.RegWriteFromWB = 0; #1;
    n_chk++; if (act_idex() !== e) begin n_fail++; $display("FAIL byp_idex: got %h want %h", act_idex(), e); end
    n_chk++; if (bus.branchTaken !== 1'b1) begin n_fail++; $display("FAIL byp_next: got %b want 1", bus.branchTaken); end
    tick(); bus.if_valid = 0;
  endtask

  task automatic test_jump();
    logic [157:0] e;
    idle(); bus.if_valid = 1; bus.instruction_in = 32'h0800_0100; bus.npc_in = 32'h4000_0004; #1;
    n_chk++; if (bus.add_outWire !== 32'h4000_0400 || bus.IFFlush_wire !== 1'b1 || bus.branchTaken !== 1'b1) begin n_fail++;
      $display("FAIL jump: got %h flush=%b taken=%b want 40000400 1 1", bus.add_outWire, bus.IFFlush_wire, bus.branchTaken); end
    e = exp_idex(32'h0800_0100, 32'h4000_0004, model_read(5'd0), model_read(5'd0));
    tick(); bus.if_valid = 0;
    n_chk++; if (act_idex() !== e) begin n_fail++; $display("FAIL jump_idex: got %h want %h", act_idex(), e); end
  endtask

  task automatic test_random();
    logic [5:0]  ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    logic [31:0] ins, npc, a, b;
    logic        v, t;
    logic [157:0] e;
    for (int i = 0; i < 80; i++) begin
      v   = ($urandom_range(0, 4) != 0);
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 6)];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      npc = $urandom;
      idle();
      bus.if_valid = v; bus.instruction_in = ins; bus.npc_in = npc;
      bus.RegWriteFromWB = $urandom_range(0, 1);
      bus.writeRegister3 = 5'($urandom_range(0, 7));
      bus.writeData = 32'($urandom_range(0, 3));
      a = model_read(ins[25:21]);
      b = model_read(ins[20:16]);
      t = v && exp_taken(ins, a, b);
      e = v ? exp_idex(ins, npc, a, b) : '0;
      #1;
      n_chk++; if (bus.branchTaken !== t || bus.PCWrite_wire !== 1'b1) begin n_fail++;
        $display("FAIL rnd_taken[%0d]: got %b pcw=%b want %b 1 ins=%h", i, bus.branchTaken, bus.PCWrite_wire, t, ins); end
      if (t) begin
        n_chk++; if (bus.add_outWire !== exp_target(ins, npc)) begin n_fail++;
          $display("FAIL rnd_target[%0d]: got %h want %h", i, bus.add_outWire, exp_target(ins, npc)); end
      end
      tick();
      n_chk++; if (act_idex() !== e) begin n_fail++; $display("FAIL rnd_idex[%0d]: got %h want %h", i, act_idex(), e); end
    end
    idle();
  endtask

  task automatic test_illegal();
    idle(); bus.if_valid = 1; bus.instruction_in = {6'h3F, 26'($urandom)}; #1;
    n_chk++; if (bus.branchTaken !== 1'b0 || bus.PCWrite_wire !== 1'b1) begin n_fail++;
      $display("FAIL ill_comb: taken=%b pcw=%b want 0 1", bus.branchTaken, bus.PCWrite_wire); end
    tick();
    n_chk++; if (act_idex() !== '0 || bus.illegal_out !== 1'b1) begin n_fail++;
      $display("FAIL ill_bubble: got %h ill=%b want 0 1", act_idex(), bus.illegal_out); end
    bus.instruction_in = 32'h012DB820; tick();
    n_chk++; if (bus.illegal_out !== 1'b1 || bus.valid_out !== 1'b1) begin n_fail++;
      $display("FAIL ill_sticky: ill=%b valid=%b want 1 1", bus.illegal_out, bus.valid_out); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    idle(); bus.if_valid = 1; bus.instruction_in = {6'h04, 5'd1, 5'd2, 16'h0008}; bus.npc_in = 32'h300;
    bus.EXRegWrite_wire = 1; bus.EXWriteReg_wire = 5'd1;
    bus.EXMemRead_wire = (EXP_LD_BR == 3); bus.EXRegRt_wire = 5'd1; #1;
    n_chk++; if (bus.PCWrite_wire !== 1'b0) begin n_fail++; $display("FAIL rst_stall_start: pcw=%b want 0", bus.PCWrite_wire); end
    tick(); bus.EXRegWrite_wire = 0; bus.EXMemRead_wire = 0; #1;
    n_chk++; if (bus.PCWrite_wire !== 1'b0) begin n_fail++; $display("FAIL rst_stall_mid: pcw=%b want 0", bus.PCWrite_wire); end
    RST = 1; tick(); RST = 0; #1;
    n_chk++; if (bus.PCWrite_wire !== 1'b1 || bus.branchTaken !== 1'b1) begin n_fail++;
      $display("FAIL rst_abort: pcw=%b taken=%b want 1 1", bus.PCWrite_wire, bus.branchTaken); end
    n_chk++; if (bus.illegal_out !== 1'b0 || bus.valid_out !== 1'b0) begin n_fail++;
      $display("FAIL rst_clear: ill=%b valid=%b want 0 0", bus.illegal_out, bus.valid_out); end
    tick(); idle();
  endtask

  initial begin
    RST = 1;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    test_reset();
    test_decode_add();
    test_load_use();
    test_branch_hazards();
    test_bypass();
    test_jump();
    test_random();
    test_illegal();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
